// File: rtl/rgb_pipe_pkg.sv
// Shared definitions for the RGB output pipe: source-mode encodings and test-bar colour mapping.
// Pure declarations; no latency or flow control of its own.
package rgb_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_FILL = 2'd1,
      MODE_BARS = 2'd2,
      MODE_INV  = 2'd3
   } mode_e;

   // Which bar-index bit lights which colour component.
   localparam int BAR_R_BIT = 2;
   localparam int BAR_G_BIT = 1;
   localparam int BAR_B_BIT = 0;

   function automatic logic [2:0] bar_mask(input logic [2:0] idx);
      return {idx[BAR_R_BIT], idx[BAR_G_BIT], idx[BAR_B_BIT]};
   endfunction

endpackage

// File: rtl/rgb_pipe_if.sv
// Pixel/sync bundle between the timing generator and the DAC-facing pipe.
// Master drives the source side and observes the pins; slave is the pipe itself.
interface rgb_pipe_if #(
   parameter int COLOR_W = 4
) ();
   logic                 i_hsync_en;
   logic                 i_vsync_en;
   logic                 i_hsync;
   logic                 i_vsync;
   logic [COLOR_W-1:0]   i_red;
   logic [COLOR_W-1:0]   i_green;
   logic [COLOR_W-1:0]   i_blue;
   logic [1:0]           i_mode;
   logic [3*COLOR_W-1:0] i_fill;

   logic [COLOR_W-1:0]   o_vga_red;
   logic [COLOR_W-1:0]   o_vga_green;
   logic [COLOR_W-1:0]   o_vga_blue;
   logic                 o_hsync;
   logic                 o_vsync;
   logic                 o_active;
   logic [1:0]           o_mode;

   modport master (
      output i_hsync_en, i_vsync_en, i_hsync, i_vsync,
      output i_red, i_green, i_blue, i_mode, i_fill,
      input  o_vga_red, o_vga_green, o_vga_blue, o_hsync, o_vsync, o_active, o_mode
   );

   modport slave (
      input  i_hsync_en, i_vsync_en, i_hsync, i_vsync,
      input  i_red, i_green, i_blue, i_mode, i_fill,
      output o_vga_red, o_vga_green, o_vga_blue, o_hsync, o_vsync, o_active, o_mode
   );
endinterface

// File: rtl/rgb_pipe_delay_line.sv
// vga_delay_line: DEPTH-register shift of a WIDTH-bit bus, synchronously reset to RST_VAL.
// Latency DEPTH cycles (DEPTH=0 is a wire); no backpressure, advances every cycle.
module vga_delay_line #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_dat,
   output logic [WIDTH-1:0] o_dat
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = i_clk ^ i_rst;
         assign o_dat          = i_dat;
      end else begin : g_regs
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else begin
               stage_q[0] <= i_dat;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign o_dat = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/rgb_pipe.sv
// Registered RGB source select + blanking with syncs delayed in lockstep with colour.
// Latency PIPE_DEPTH cycles for every output except o_mode; no backpressure.
module rgb_pipe
   import rgb_pkg::*;
#(
   parameter int   COLOR_W    = 4,
   parameter int   PIPE_DEPTH = 2,
   parameter int   BAR_W      = 80,
   parameter logic SYNC_IDLE  = 1'b1
) (
   input  logic      i_clk,
   input  logic      i_rst,
   rgb_pipe_if.slave bus
);

   localparam int RGB_W = 3 * COLOR_W;
   localparam int BUS_W = RGB_W + 3;
   localparam int CNT_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [BUS_W-1:0] RST_BUS = {SYNC_IDLE, SYNC_IDLE, 1'b0, {RGB_W{1'b0}}};

   logic             active;
   logic             vsync_en_q;
   mode_e            mode_q, mode_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [2:0]       bar_idx_q, bar_idx_d;
   logic [2:0]       bar_on;
   logic [RGB_W-1:0] src_rgb, bar_rgb, rgb_d;
   logic [BUS_W-1:0] s1_q, s1_d, out_bus;

   always_comb begin
      active  = bus.i_vsync_en & bus.i_hsync_en;
      src_rgb = {bus.i_red, bus.i_green, bus.i_blue};

      // Mode only swaps at the falling edge of the vertical active region.
      mode_d = mode_q;
      if (vsync_en_q && !bus.i_vsync_en) mode_d = mode_e'(bus.i_mode);

      pix_cnt_d = '0;
      bar_idx_d = '0;
      if (active) begin
         if (pix_cnt_q == CNT_W'(BAR_W - 1)) begin
            pix_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
         end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
            bar_idx_d = bar_idx_q;
         end
      end

      bar_on  = bar_mask(bar_idx_q);
      bar_rgb = {{COLOR_W{bar_on[2]}}, {COLOR_W{bar_on[1]}}, {COLOR_W{bar_on[0]}}};

      rgb_d = src_rgb;
      case (mode_q)
         MODE_PASS: rgb_d = src_rgb;
         MODE_FILL: rgb_d = bus.i_fill;
         MODE_BARS: rgb_d = bar_rgb;
         MODE_INV:  rgb_d = ~src_rgb;
         default:   rgb_d = src_rgb;
      endcase
      if (!active) rgb_d = '0;

      s1_d = {bus.i_hsync, bus.i_vsync, active, rgb_d};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_q       <= RST_BUS;
         mode_q     <= MODE_PASS;
         pix_cnt_q  <= '0;
         bar_idx_q  <= '0;
         vsync_en_q <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         mode_q     <= mode_d;
         pix_cnt_q  <= pix_cnt_d;
         bar_idx_q  <= bar_idx_d;
         vsync_en_q <= bus.i_vsync_en;
      end
   end

   vga_delay_line #(
      .WIDTH   (BUS_W),
      .DEPTH   (PIPE_DEPTH - 1),
      .RST_VAL (RST_BUS)
   ) u_delay (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_dat (s1_q),
      .o_dat (out_bus)
   );

   assign bus.o_hsync     = out_bus[BUS_W-1];
   assign bus.o_vsync     = out_bus[BUS_W-2];
   assign bus.o_active    = out_bus[BUS_W-3];
   assign bus.o_vga_red   = out_bus[3*COLOR_W-1 -: COLOR_W];
   assign bus.o_vga_green = out_bus[2*COLOR_W-1 -: COLOR_W];
   assign bus.o_vga_blue  = out_bus[COLOR_W-1:0];
   assign bus.o_mode      = mode_q;

endmodule

// File: tb/tb_rgb_pipe.sv
// Bench for rgb_pipe: directed literal checks plus randomized traffic against a
// frame/line-level model of the output pins.
module tb_rgb_pipe;

   localparam int CW = 4;
   localparam int PD = 2;
   localparam int BW = 80;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rgb_pipe_if #(.COLOR_W(CW)) vif ();

   rgb_pipe #(
      .COLOR_W    (CW),
      .PIPE_DEPTH (PD),
      .BAR_W      (BW),
      .SYNC_IDLE  (1'b1)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (vif)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        act;
      logic [11:0] rgb;
   } obs_t;

   localparam obs_t OBS_RST = '{hs: 1'b1, vs: 1'b1, act: 1'b0, rgb: 12'h000};

   obs_t       mq[$];
   logic [1:0] m_shadow;
   int         m_pix;
   logic       m_prev_ven;
   bit         m_live = 1'b0;

   // Test-bar colour from the pixel's position in the current active line.
   function automatic logic [11:0] bar_colour(int pix);
      int b;
      b = (pix / BW) % 8;
      return {(b >= 4) ? 4'hF : 4'h0, ((b / 2) % 2 == 1) ? 4'hF : 4'h0, (b % 2 == 1) ? 4'hF : 4'h0};
   endfunction

   function automatic logic [11:0] out_rgb();
      return {vif.o_vga_red, vif.o_vga_green, vif.o_vga_blue};
   endfunction

   always @(posedge clk) begin
      obs_t        v;
      logic        act;
      logic [11:0] src;
      if (rst) begin
         mq.delete();
         for (int i = 0; i < PD; i++) mq.push_back(OBS_RST);
         m_shadow   = 2'd0;
         m_pix      = 0;
         m_prev_ven = 1'b0;
         m_live     = 1'b1;
      end else if (m_live) begin
         act   = vif.i_vsync_en & vif.i_hsync_en;
         src   = {vif.i_red, vif.i_green, vif.i_blue};
         v.hs  = vif.i_hsync;
         v.vs  = vif.i_vsync;
         v.act = act;
         case (m_shadow)
            2'd0:    v.rgb = src;
            2'd1:    v.rgb = vif.i_fill;
            2'd2:    v.rgb = bar_colour(m_pix);
            default: v.rgb = ~src;
         endcase
         if (!act) v.rgb = 12'h000;
         if (act) m_pix++;
         else     m_pix = 0;
         if (m_prev_ven && !vif.i_vsync_en) m_shadow = vif.i_mode;
         m_prev_ven = vif.i_vsync_en;
         mq.push_back(v);
         void'(mq.pop_front());
      end
   end

   always @(negedge clk) begin
      obs_t got;
      if (m_live) begin
         got.hs  = vif.o_hsync;
         got.vs  = vif.o_vsync;
         got.act = vif.o_active;
         got.rgb = out_rgb();
         checks++;
         if (got !== mq[0] || vif.o_mode !== m_shadow) begin
            failures++;
            $display("FAIL model_cycle t=%0t: got hs=%b vs=%b act=%b rgb=%h mode=%0d, want hs=%b vs=%b act=%b rgb=%h mode=%0d",
                     $time, got.hs, got.vs, got.act, got.rgb, vif.o_mode,
                     mq[0].hs, mq[0].vs, mq[0].act, mq[0].rgb, m_shadow);
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_rgb(input logic [11:0] c);
      {vif.i_red, vif.i_green, vif.i_blue} = c;
   endtask

   logic [11:0] cap [0:639];

   // Drive n active pixels, then capture what the pins showed for each of them.
   task automatic run_line(input int n);
      for (int p = 0; p < n + PD; p++) begin
         if (p >= PD) cap[p-PD] = out_rgb();
         vif.i_hsync_en = (p < n);
         cyc(1);
      end
      vif.i_hsync_en = 1'b0;
   endtask

   initial begin
      int len;
      rst            = 1'b1;
      vif.i_hsync_en = 1'b0;
      vif.i_vsync_en = 1'b0;
      vif.i_hsync    = 1'b1;
      vif.i_vsync    = 1'b1;
      vif.i_mode     = 2'd0;
      vif.i_fill     = 12'h000;
      set_rgb(12'h000);
      cyc(3);
      lit("reset_rgb",    32'(out_rgb()),    32'h000);
      lit("reset_active", 32'(vif.o_active), 32'h0);
      lit("reset_hsync",  32'(vif.o_hsync),  32'h1);
      lit("reset_vsync",  32'(vif.o_vsync),  32'h1);
      lit("reset_mode",   32'(vif.o_mode),   32'h0);

      // Pass-through latency and blanking
      rst            = 1'b0;
      vif.i_vsync_en = 1'b1;
      vif.i_hsync_en = 1'b1;
      set_rgb(12'hA53);
      cyc(1);
      vif.i_hsync_en = 1'b0;
      cyc(1);
      lit("pass_a53_rgb",    32'(out_rgb()),    32'hA53);
      lit("pass_a53_active", 32'(vif.o_active), 32'h1);
      cyc(1);
      lit("blank_rgb",    32'(out_rgb()),    32'h000);
      lit("blank_active", 32'(vif.o_active), 32'h0);

      // hsync pulse alignment
      vif.i_hsync_en = 1'b1;
      vif.i_hsync    = 1'b0;
      cyc(1);
      vif.i_hsync = 1'b1;
      lit("hsync_t1", 32'(vif.o_hsync), 32'h1);
      cyc(1);
      lit("hsync_t2",        32'(vif.o_hsync),  32'h0);
      lit("hsync_t2_active", 32'(vif.o_active), 32'h1);
      cyc(1);
      lit("hsync_t3", 32'(vif.o_hsync), 32'h1);

      // Fill requested mid-frame takes effect only after vsync_en falls
      set_rgb(12'h123);
      vif.i_mode = 2'd1;
      vif.i_fill = 12'h0F0;
      cyc(3);
      lit("fill_pending_mode", 32'(vif.o_mode), 32'h0);
      lit("fill_pending_rgb",  32'(out_rgb()),  32'h123);
      vif.i_vsync_en = 1'b0;
      cyc(1);
      lit("fill_mode_loaded", 32'(vif.o_mode), 32'h1);
      vif.i_vsync_en = 1'b1;
      cyc(2);
      lit("fill_rgb", 32'(out_rgb()), 32'h0F0);

      // Test bars across a 640-pixel line, then a fresh line
      vif.i_mode     = 2'd2;
      vif.i_vsync_en = 1'b0;
      cyc(1);
      lit("bars_mode", 32'(vif.o_mode), 32'h2);
      vif.i_hsync_en = 1'b0;
      vif.i_vsync_en = 1'b1;
      cyc(2);
      run_line(640);
      lit("bar_px0",   32'(cap[0]),   32'h000);
      lit("bar_px79",  32'(cap[79]),  32'h000);
      lit("bar_px80",  32'(cap[80]),  32'h00F);
      lit("bar_px160", 32'(cap[160]), 32'h0F0);
      lit("bar_px320", 32'(cap[320]), 32'hF00);
      lit("bar_px560", 32'(cap[560]), 32'hFFF);
      lit("bar_px639", 32'(cap[639]), 32'hFFF);
      cyc(3);
      run_line(100);
      lit("bar_line2_px0",  32'(cap[0]),  32'h000);
      lit("bar_line2_px80", 32'(cap[80]), 32'h00F);

      // Inversion, then reset mid-line
      vif.i_mode     = 2'd3;
      vif.i_vsync_en = 1'b0;
      cyc(1);
      lit("inv_mode", 32'(vif.o_mode), 32'h3);
      vif.i_vsync_en = 1'b1;
      vif.i_hsync_en = 1'b1;
      set_rgb(12'h123);
      cyc(2);
      lit("inv_rgb", 32'(out_rgb()), 32'hEDC);
      rst = 1'b1;
      cyc(1);
      lit("midrst_rgb",    32'(out_rgb()),    32'h000);
      lit("midrst_active", 32'(vif.o_active), 32'h0);
      lit("midrst_hsync",  32'(vif.o_hsync),  32'h1);
      lit("midrst_mode",   32'(vif.o_mode),   32'h0);
      rst = 1'b0;

      // Randomized segments of active/blank runs with frame edges and rare resets
      for (int s = 0; s < 40; s++) begin
         len            = $urandom_range(1, 300);
         vif.i_hsync_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) vif.i_vsync_en = ~vif.i_vsync_en;
         vif.i_mode = 2'($urandom_range(0, 3));
         for (int c = 0; c < len; c++) begin
            set_rgb(12'($urandom));
            if ($urandom_range(0, 15) == 0) vif.i_fill = 12'($urandom);
            vif.i_hsync = ($urandom_range(0, 15) != 0);
            vif.i_vsync = ($urandom_range(0, 31) != 0);
            rst         = ($urandom_range(0, 299) == 0);
            cyc(1);
         end
      end
      rst = 1'b0;
      cyc(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rgb_pipe.md
Name: rgb_pipe

Overview:
- Parametrised, registered successor to the combinational RGB blanking stage; sits between the sync/timing generator and the VGA DAC pins.
- Selects a pixel source per frame: pass-through, solid fill, 8-bar test pattern or inverted video.
- Forces black outside the active area.
- Delays hsync/vsync by the same number of cycles as colour, so pins stay aligned.

Parameters:
- COLOR_W, 4, bits per colour component.
- PIPE_DEPTH, 2, total cycles from input to output (>=1).
- BAR_W, 80, active pixels per test-pattern bar (>=1).
- SYNC_IDLE, 1, reset/idle level of o_hsync/o_vsync.

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  synchronous active-high reset
- i_hsync_en  in  1  horizontal active region
- i_vsync_en  in  1  vertical active region
- i_hsync  in  1  horizontal sync pulse from timing generator
- i_vsync  in  1  vertical sync pulse from timing generator
- i_red, i_green, i_blue  in  COLOR_W each  source pixel
- i_mode  in  2  requested mode: 0 pass, 1 fill, 2 bars, 3 invert
- i_fill  in  3*COLOR_W  fill colour {r,g,b}
- o_vga_red, o_vga_green, o_vga_blue  out  COLOR_W each  DAC colour
- o_hsync, o_vsync  out  1  delayed syncs
- o_active  out  1  delayed active flag
- o_mode  out  2  mode currently in effect

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Active flag: active = i_vsync_en & i_hsync_en.
- Mode shadow:
  - Register vsync_en_q tracks the previous i_vsync_en.
  - On the cycle where vsync_en_q=1 and i_vsync_en=0 (end of active frame), the shadow loads i_mode.
  - Mode changes therefore never tear mid-frame. o_mode = shadow.
  - i_fill is sampled every cycle; it is not shadowed.
- Bar generator:
  - Counters pix_cnt (0..BAR_W-1) and bar_idx (3 bits).
  - While active: pix_cnt increments. At BAR_W-1 it wraps to 0 and bar_idx increments mod 8 (wrap 7->0).
  - While not active: both counters clear to 0, so every line starts at bar 0.
  - Bar colour: red = all-ones if bar_idx[2], green = all-ones if bar_idx[1], blue = all-ones if bar_idx[0]; otherwise 0.
- Stage 1 (registered), colour by mode:
  - mode 0: {i_red,i_green,i_blue}
  - mode 1: i_fill
  - mode 2: bar colour
  - mode 3: bitwise inverse of the input
  - Forced to 0 when active=0.
  - Stage 1 also registers i_hsync, i_vsync and active.
- Stages 2..PIPE_DEPTH: plain delay of all stage-1 fields.
- Latency: exactly PIPE_DEPTH cycles for colour, syncs and o_active alike.
- Reset:
  - Colour outputs 0; o_active 0; o_hsync/o_vsync = SYNC_IDLE.
  - Every pipeline stage is cleared to the same values.
  - Mode shadow 0; counters 0; vsync_en_q 0.
- Reset mid-line:
  - Outputs go to reset values on the next edge.
  - Counters restart at 0 on the first active pixel after reset deasserts.
- Simultaneous events:
  - i_mode changing on the same cycle as the frame-end edge is loaded.
  - Frame-end during reset: reset wins.
- Widths: all colour arithmetic is COLOR_W wide with no carries; the inversion is bitwise.

Decomposition:
- Shared package/header `rgb_pkg`:
  - Mode encodings MODE_PASS=0, MODE_FILL=1, MODE_BARS=2, MODE_INV=3.
  - Bar colour index bit assignment.
- Sub-module `vga_delay_line`:
  - Parameters WIDTH, DEPTH, RST_VAL; synchronous reset.
  - Used for stages 2..PIPE_DEPTH, carrying {hsync, vsync, active, rgb} as one bus.
  - DEPTH=0 is a pass-through.

Test Plan:
- Reset held 3 cycles with COLOR_W=4, PIPE_DEPTH=2 -> colour outputs 0, o_active=0, o_hsync=o_vsync=1, o_mode=0.
- Mode 0, active, input rgb=0xA53 at cycle t -> o_vga={A,5,3} and o_active=1 at t+2. The same input with i_hsync_en=0 -> 0x000, o_active=0.
- i_hsync pulse at cycle t -> o_hsync mirrors it at t+2, with colour blanking edges aligned to o_active.
- i_mode=1 mid-frame with i_fill=0x0F0:
  - Output stays pass-through until i_vsync_en falls.
  - o_mode=1 from the next cycle.
  - The next frame shows 0x0F0 on every active pixel.
- Mode 2, BAR_W=80, 640 active pixels:
  - Bar 0 (pixels 0-79) = 0x000, bar 1 = 0x00F, bar 4 = 0xF00, pixels 560-639 = 0xFFF.
  - The following line restarts at 0x000.
- Mode 3, input 0x123 -> output 0xEDC. Reset asserted mid-line -> outputs reset next edge, o_mode returns to 0.
